mips32_multicycle_ctrl: RTL
===========================

Name: mips32_multicycle_ctrl

Overview:
- Sequencing controller for the multi-cycle variant of the MIPS32 core. Instruction and data accesses share one memory port, and the ALU/shifter is reused across phases.
- Each instruction is stepped through FETCH, DECODE, EXEC, MEM and WB.
- Drives the write enables and mux selects for PC, IR, the operand latches, the memory port and the register file.
- Counts retired instructions and halts on illegal opcodes, trapping overflow, or memory timeout.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for mem_ready before halting; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26] of the latched instruction.
- cond_true  in  1  branch condition from the datapath condition selector.
- overflow  in  1  trapping overflow from the ALU, already qualified by the datapath.
- mem_ready  in  1  memory completion for the current request.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store).
- mem_addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  latch memory data into IR.
- ab_we  out  1  latch Rs_out/Rt_out into operand registers A/B.
- pc_we  out  1  write PC.
- pc_src  out  2  next-PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- rf_we  out  1  register file write; the datapath expands it to byte enables 1111.
- wb_sel  out  1  writeback source: 0 = ALU/shift result, 1 = memory data.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- halted  out  1  controller is in HALT.
- halt_cause  out  2  0 = none, 1 = illegal opcode, 2 = overflow, 3 = memory timeout.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register, instr_count, halt_cause and the wait counter are registered.
- Control outputs are combinational from state, the latched opcode class and the inputs.
- All control outputs are forced to 0 while reset is high.
- Reset (at any point, including mid-memory-wait): state=FETCH, instr_count=0, halt_cause=0, wait counter=0. An outstanding memory request is abandoned.
- Opcode classes:
  - 000000: R-type.
  - 001xxx: I-ALU.
  - 100xxx: load.
  - 101xxx: store.
  - 000100–000111: branch.
  - 000010, 000011: jump.
  - All others: illegal.
- FETCH:
  - Outputs: mem_req=1, mem_addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0 in that same cycle; next state DECODE.
- DECODE:
  - ab_we=1 for one cycle.
  - Illegal opcode -> HALT, halt_cause=1.
  - Otherwise -> EXEC.
- EXEC:
  - R-type / I-ALU: if overflow -> HALT, halt_cause=2, no register write. Otherwise -> WB.
  - Load / store: -> MEM.
  - Branch: pc_we=cond_true, pc_src=1; retire; -> FETCH.
  - Jump: pc_we=1, pc_src=2; retire; -> FETCH.
- MEM:
  - Outputs: mem_req=1, mem_addr_sel=1; mem_we=1 for store.
  - On mem_ready: load -> WB; store retires -> FETCH.
- WB:
  - rf_we=1; wb_sel=1 for load, 0 otherwise.
  - Retire; -> FETCH.
- HALT:
  - All control outputs 0; halted=1.
  - Held until reset; mem_ready and overflow are ignored.
- Retire: instr_count increments by 1 in the retiring cycle and wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored whenever mem_req=0.
- Memory timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ready still low -> HALT, halt_cause=3.
  - mem_ready arriving in the same cycle the limit is reached wins: the access completes normally.
- Latency with zero-wait memory:
  - R-type / I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / jump: 3 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, then R-type add (opcode 000000) with mem_ready tied 1 -> states 0,1,2,4,0; ir_we and pc_we high in cycle 0, rf_we high in cycle 3 with wb_sel=0; instr_count=1.
- Load (100011) with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_addr_sel=1 and mem_we=0; then WB with wb_sel=1; 7 cycles total; instr_count=1.
- Branch (000100): cond_true=1 -> pc_we=1, pc_src=1 in EXEC; cond_true=0 -> pc_we=0. Both cases retire in 3 cycles.
- Illegal opcode 010000 -> HALT after DECODE, halt_cause=1, halted=1; all control outputs stay 0 for 20 cycles despite mem_ready toggling; reset returns to FETCH with instr_count=0.
- I-ALU (001000) with overflow=1 in EXEC -> HALT, halt_cause=2, rf_we never asserted.
- MEM_TIMEOUT=4 with mem_ready stuck 0 in FETCH -> HALT after 4 wait cycles, halt_cause=3. Repeat with mem_ready rising on the 4th cycle -> normal fetch, no halt.

Source files
------------

// File: rtl/mips32_multicycle_ctrl.sv
// mips32_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the shared-memory multi-cycle MIPS32 core.
// Retires instructions, and halts on an illegal opcode, a trapping overflow or a memory timeout.
`default_nettype none

module mips32_multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             cond_true,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             ab_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam int              WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            cur_state, nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;
  logic [1:0]        new_cause;
  logic              is_alu, is_load, is_store, is_branch, is_jump;
  logic              mem_timeout;

  always_comb begin
    is_alu    = (opcode == 6'b000000) || (opcode[5:3] == 3'b001);
    is_load   = (opcode[5:3] == 3'b100);
    is_store  = (opcode[5:3] == 3'b101);
    is_branch = (opcode[5:2] == 4'b0001);
    is_jump   = (opcode[5:1] == 5'b00001);
  end

  // The access that is still unanswered on its last allowed cycle gives up here.
  assign mem_timeout = TIMEOUT_EN && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt_state    = cur_state;
    retire       = 1'b0;
    new_cause    = 2'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    ab_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    rf_we        = 1'b0;
    wb_sel       = 1'b0;
    case (cur_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          nxt_state = S_DECODE;
        end else if (mem_timeout) begin
          nxt_state = S_HALT;
          new_cause = 2'd3;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        if (is_alu || is_load || is_store || is_branch || is_jump) begin
          nxt_state = S_EXEC;
        end else begin
          nxt_state = S_HALT;
          new_cause = 2'd1;
        end
      end
      S_EXEC: begin
        if (is_alu) begin
          if (overflow) begin
            nxt_state = S_HALT;
            new_cause = 2'd2;
          end else begin
            nxt_state = S_WB;
          end
        end else if (is_load || is_store) begin
          nxt_state = S_MEM;
        end else if (is_branch) begin
          pc_we     = cond_true;
          pc_src    = 2'd1;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else if (is_jump) begin
          pc_we     = 1'b1;
          pc_src    = 2'd2;
          retire    = 1'b1;
          nxt_state = S_FETCH;
        end else begin
          nxt_state = S_HALT;
          new_cause = 2'd1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          if (is_load) begin
            nxt_state = S_WB;
          end else begin
            retire    = 1'b1;
            nxt_state = S_FETCH;
          end
        end else if (mem_timeout) begin
          nxt_state = S_HALT;
          new_cause = 2'd3;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        wb_sel    = is_load;
        retire    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_HALT: nxt_state = S_HALT;
      default: nxt_state = S_FETCH;
    endcase
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      ab_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'd0;
      rf_we        = 1'b0;
      wb_sel       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state   <= S_FETCH;
      instr_count <= '0;
      halt_cause  <= 2'd0;
      wait_cnt    <= '0;
    end else begin
      cur_state <= nxt_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (nxt_state == S_HALT && cur_state != S_HALT) halt_cause <= new_cause;
      // Every entry into FETCH or MEM comes from another state, so a state change restarts the count.
      if (nxt_state != cur_state) wait_cnt <= '0;
      else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign state  = cur_state;
  assign halted = (cur_state == S_HALT);

endmodule

`default_nettype wire
